// File: rtl/sw40g_width_pkg.sv
// rtl/sw40g_width_pkg.sv - shared width/segment helpers for the sw40g AXI-Stream gearboxes
package sw40g_width_pkg;
  localparam int MAX_KEEP_W = 128;

  typedef logic [31:0] stat_frames_t;
  typedef logic [15:0] stat_null_t;

  function automatic int seg_count(input int s_w, input int m_w);
    return s_w / m_w;
  endfunction

  // Highest segment whose keep slice has any bit set; 0 when keep is all-zero.
  function automatic int last_seg_idx(input logic [MAX_KEEP_W-1:0] keep, input int seg_n,
                                      input int keep_w);
    int idx;
    idx = 0;
    for (int b = 0; b < MAX_KEEP_W; b++) begin
      if (b < keep_w && keep[b]) idx = b / (keep_w / seg_n);
    end
    return idx;
  endfunction
endpackage

// File: rtl/sw40g_axis_wide2narrow_tx.sv
// rtl/sw40g_axis_wide2narrow_tx.sv - wide-to-narrow AXI-Stream TX gearbox, one buffered wide beat
module sw40g_axis_wide2narrow_tx
  import sw40g_width_pkg::*;
#(
  parameter int S_DATA_W = 256,
  parameter int M_DATA_W = 64,
  parameter int USER_W   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [S_DATA_W-1:0]   s_axis_tdata,
  input  logic [S_DATA_W/8-1:0] s_axis_tkeep,
  input  logic [USER_W-1:0]     s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [M_DATA_W-1:0]   m_axis_tdata,
  output logic [M_DATA_W/8-1:0] m_axis_tkeep,
  output logic [USER_W-1:0]     m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           stat_frames,
  output logic [15:0]           stat_null_beats,
  output logic                  busy
);
  localparam int SEG_N    = seg_count(S_DATA_W, M_DATA_W);
  localparam int S_KEEP_W = S_DATA_W / 8;
  localparam int M_KEEP_W = M_DATA_W / 8;
  localparam int SEG_W    = (SEG_N > 1) ? $clog2(SEG_N) : 1;

  generate
    if ((S_DATA_W % M_DATA_W) != 0 || (M_DATA_W % 8) != 0) begin : g_bad_params
      $error("sw40g_axis_wide2narrow_tx: S_DATA_W must be a multiple of M_DATA_W, M_DATA_W of 8");
    end
  endgenerate

  logic                  buf_valid_q, buf_valid_d;
  logic [SEG_W-1:0]      seg_idx_q, seg_idx_d;
  logic [SEG_W-1:0]      last_seg_q, last_seg_d;
  logic [S_DATA_W-1:0]   buf_data_q, buf_data_d;
  logic [S_KEEP_W-1:0]   buf_keep_q, buf_keep_d;
  logic [USER_W-1:0]     buf_user_q, buf_user_d;
  logic                  buf_last_q, buf_last_d;
  stat_frames_t          stat_frames_q, stat_frames_d;
  stat_null_t            stat_null_q, stat_null_d;

  logic                  at_last, m_hs, s_hs, null_beat;
  logic [MAX_KEEP_W-1:0] keep_ext;

  always_comb begin
    at_last       = (seg_idx_q == last_seg_q);
    m_hs          = buf_valid_q && m_axis_tready;
    s_axis_tready = !buf_valid_q || (m_axis_tready && at_last);
    s_hs          = s_axis_tvalid && s_axis_tready;
    null_beat     = (s_axis_tkeep == '0) && !s_axis_tlast;
    keep_ext      = '0;
    keep_ext[S_KEEP_W-1:0] = s_axis_tkeep;

    m_axis_tvalid = buf_valid_q;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    if (buf_valid_q) begin
      m_axis_tdata = buf_data_q[int'(seg_idx_q)*M_DATA_W +: M_DATA_W];
      m_axis_tkeep = buf_keep_q[int'(seg_idx_q)*M_KEEP_W +: M_KEEP_W];
      m_axis_tuser = buf_user_q;
      m_axis_tlast = buf_last_q && at_last;
    end
  end

  always_comb begin
    buf_valid_d   = buf_valid_q;
    seg_idx_d     = seg_idx_q;
    last_seg_d    = last_seg_q;
    buf_data_d    = buf_data_q;
    buf_keep_d    = buf_keep_q;
    buf_user_d    = buf_user_q;
    buf_last_d    = buf_last_q;
    stat_frames_d = stat_frames_q;
    stat_null_d   = stat_null_q;

    if (m_hs) begin
      if (at_last) buf_valid_d = 1'b0;
      else         seg_idx_d   = seg_idx_q + SEG_W'(1);
      if (m_axis_tlast) stat_frames_d = stat_frames_q + 32'd1;
    end

    // A load here overrides the final-segment clear above, giving bubble-free back-to-back beats.
    if (s_hs) begin
      if (null_beat) begin
        if (stat_null_q != '1) stat_null_d = stat_null_q + 16'd1;
      end else begin
        buf_valid_d = 1'b1;
        seg_idx_d   = '0;
        last_seg_d  = SEG_W'(last_seg_idx(keep_ext, SEG_N, S_KEEP_W));
        buf_data_d  = s_axis_tdata;
        buf_keep_d  = s_axis_tkeep;
        buf_user_d  = s_axis_tuser;
        buf_last_d  = s_axis_tlast;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q   <= 1'b0;
      seg_idx_q     <= '0;
      last_seg_q    <= '0;
      buf_data_q    <= '0;
      buf_keep_q    <= '0;
      buf_user_q    <= '0;
      buf_last_q    <= 1'b0;
      stat_frames_q <= '0;
      stat_null_q   <= '0;
    end else begin
      buf_valid_q   <= buf_valid_d;
      seg_idx_q     <= seg_idx_d;
      last_seg_q    <= last_seg_d;
      buf_data_q    <= buf_data_d;
      buf_keep_q    <= buf_keep_d;
      buf_user_q    <= buf_user_d;
      buf_last_q    <= buf_last_d;
      stat_frames_q <= stat_frames_d;
      stat_null_q   <= stat_null_d;
    end
  end

  assign stat_frames     = stat_frames_q;
  assign stat_null_beats = stat_null_q;
  assign busy            = buf_valid_q;
endmodule

// File: tb/tb_sw40g_axis_wide2narrow_tx.sv
// tb/tb_sw40g_axis_wide2narrow_tx.sv - self-checking bench for the wide-to-narrow TX gearbox
module tb_sw40g_axis_wide2narrow_tx;
  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         user;
    logic         last;
  } wbeat_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        user;
    logic        last;
  } nbeat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic [0:0]   s_axis_tuser;
  logic         s_axis_tlast;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic [0:0]   m_axis_tuser;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [31:0]  stat_frames;
  logic [15:0]  stat_null_beats;
  logic         busy;

  sw40g_axis_wide2narrow_tx dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .stat_frames(stat_frames), .stat_null_beats(stat_null_beats), .busy(busy)
  );

  always #5 clk = ~clk;

  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     stall_viol = 0;
  int     cmp_idx = 0;
  int     exp_frames = 0;
  int     exp_null = 0;
  wbeat_t in_q[$];
  nbeat_t exp_q[$];
  nbeat_t obs_q[$];
  int     obs_cyc[$];
  nbeat_t cur_beat, prev_beat;
  logic   prev_stall = 1'b0;

  assign cur_beat = '{data: m_axis_tdata, keep: m_axis_tkeep, user: m_axis_tuser[0],
                      last: m_axis_tlast};

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records handshakes that will complete on the coming edge, checks stall holding.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && (cur_beat !== prev_beat)) stall_viol++;
      if (m_axis_tvalid && !m_axis_tready && s_axis_tready) stall_viol++;
      if (m_axis_tvalid && m_axis_tready) begin
        obs_q.push_back(cur_beat);
        obs_cyc.push_back(cyc);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = cur_beat;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a wide beat becomes segments 0..highest-nonzero-keep segment, in byte order.
  task automatic model_push(input wbeat_t w);
    int     hi;
    nbeat_t n;
    if (w.keep == 32'h0 && !w.last) begin
      if (exp_null < 65535) exp_null++;
      return;
    end
    hi = 0;
    for (int s = 0; s < 4; s++) if (w.keep[s*8 +: 8] != 8'h0) hi = s;
    for (int s = 0; s <= hi; s++) begin
      n.data = w.data[s*64 +: 64];
      n.keep = w.keep[s*8 +: 8];
      n.user = w.user;
      n.last = w.last && (s == hi);
      exp_q.push_back(n);
      if (n.last) exp_frames++;
    end
  endtask

  function automatic wbeat_t mk_beat(input logic [31:0] keep, input logic last);
    wbeat_t w;
    for (int i = 0; i < 8; i++) w.data[i*32 +: 32] = $urandom;
    w.keep = keep;
    w.user = 1'($urandom_range(1));
    w.last = last;
    return w;
  endfunction

  // ready_mode >= 0: percent chance of m_axis_tready; < 0: repeating 1,0,0,1 pattern.
  task automatic run(input int ready_mode, output int s_gap_bad);
    int budget;
    int last_s;
    budget    = 0;
    last_s    = -1;
    s_gap_bad = 0;
    while ((in_q.size() > 0 || obs_q.size() < exp_q.size()) && budget < 20000) begin
      @(posedge clk); #1;
      if (in_q.size() > 0) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = in_q[0].data;
        s_axis_tkeep  = in_q[0].keep;
        s_axis_tuser  = in_q[0].user;
        s_axis_tlast  = in_q[0].last;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      if (ready_mode < 0) m_axis_tready = (budget % 4 == 0) || (budget % 4 == 3);
      else                m_axis_tready = ($urandom_range(99) < ready_mode);
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) begin
        model_push(in_q.pop_front());
        if (last_s >= 0 && cyc - last_s != 4) s_gap_bad++;
        last_s = cyc;
      end
      budget++;
    end
    chk("run_timeout", 64'(budget < 20000), 64'd1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic compare_all();
    nbeat_t got;
    chk("beat_count", 64'(obs_q.size()), 64'(exp_q.size()));
    while (cmp_idx < exp_q.size()) begin
      got = (cmp_idx < obs_q.size()) ? obs_q[cmp_idx] : nbeat_t'(0);
      checks++;
      assert (got === exp_q[cmp_idx]) else begin
        errors++;
        $error("FAIL beat%0d got=%h exp=%h", cmp_idx, got, exp_q[cmp_idx]);
      end
      cmp_idx++;
    end
    chk("stat_frames", 64'(stat_frames), 64'(exp_frames));
    chk("stat_null", 64'(stat_null_beats), 64'(exp_null));
  endtask

  initial begin
    int     gap;
    int     base;
    int     bud;
    int     nb;
    int     len;
    wbeat_t w;
    logic [31:0] k;

    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tuser = '0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frames", 64'(stat_frames), 64'd0);
    chk("rst_null", 64'(stat_null_beats), 64'd0);
    chk("rst_m_tdata", m_axis_tdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_axis_tready = 1'b1;

    // Full frame: two all-ones beats, last on the second.
    base = obs_q.size();
    in_q.push_back(mk_beat(32'hFFFF_FFFF, 1'b0));
    in_q.push_back(mk_beat(32'hFFFF_FFFF, 1'b1));
    run(100, gap);
    chk("full_nbeats", 64'(obs_q.size() - base), 64'd8);
    chk("full_keep0", 64'(obs_q[base].keep), 64'hFF);
    chk("full_last7", 64'(obs_q[base+7].last), 64'd1);
    chk("full_last6", 64'(obs_q[base+6].last), 64'd0);
    chk("full_consec", 64'(obs_cyc[base+7] - obs_cyc[base]), 64'd7);
    chk("full_frames", 64'(stat_frames), 64'd1);
    compare_all();

    // Short tail: only segments 0 and 1 carry data.
    base = obs_q.size();
    in_q.push_back(mk_beat(32'h0000_0FFF, 1'b1));
    run(100, gap);
    chk("tail_nbeats", 64'(obs_q.size() - base), 64'd2);
    chk("tail_keep0", 64'(obs_q[base].keep), 64'hFF);
    chk("tail_keep1", 64'(obs_q[base+1].keep), 64'h0F);
    chk("tail_last1", 64'(obs_q[base+1].last), 64'd1);
    compare_all();

    // Backpressure pattern 1,0,0,1 through a multi-beat frame.
    in_q.push_back(mk_beat(32'hFFFF_FFFF, 1'b0));
    in_q.push_back(mk_beat(32'h00FF_F0FF, 1'b0));
    in_q.push_back(mk_beat(32'h0000_00FF, 1'b1));
    run(-1, gap);
    compare_all();

    // Null beats: non-last dropped and counted; last with empty keep gives one empty tlast beat.
    base = obs_q.size();
    in_q.push_back(mk_beat(32'h0, 1'b0));
    run(100, gap);
    chk("null_nbeats", 64'(obs_q.size() - base), 64'd0);
    chk("null_cnt", 64'(stat_null_beats), 64'd1);
    in_q.push_back(mk_beat(32'h0, 1'b1));
    run(100, gap);
    chk("nulllast_nbeats", 64'(obs_q.size() - base), 64'd1);
    chk("nulllast_keep", 64'(obs_q[base].keep), 64'h00);
    chk("nulllast_last", 64'(obs_q[base].last), 64'd1);
    compare_all();

    // Back-to-back full beats: one load every 4 cycles, no output bubble.
    base = obs_q.size();
    for (int i = 0; i < 10; i++) in_q.push_back(mk_beat(32'hFFFF_FFFF, (i == 4) || (i == 9)));
    run(100, gap);
    chk("b2b_s_gap", 64'(gap), 64'd0);
    chk("b2b_m_span", 64'(obs_cyc[obs_q.size()-1] - obs_cyc[base] + 1), 64'd40);
    compare_all();

    // 100 random frames under random backpressure.
    for (int f = 0; f < 100; f++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb - 1; b++) begin
        case ($urandom_range(9))
          0:       k = 32'h0;
          1:       k = $urandom;
          default: k = 32'hFFFF_FFFF;
        endcase
        in_q.push_back(mk_beat(k, 1'b0));
      end
      if ($urandom_range(1) == 1) begin
        len = $urandom_range(0, 32);
        k = (len == 32) ? 32'hFFFF_FFFF : ((32'h1 << len) - 32'h1);
      end else begin
        k = $urandom;
      end
      in_q.push_back(mk_beat(k, 1'b1));
    end
    run(70, gap);
    compare_all();

    // Reset mid-frame after two narrow beats have left.
    base = obs_q.size();
    w = mk_beat(32'hFFFF_FFFF, 1'b1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b1; s_axis_tdata = w.data; s_axis_tkeep = w.keep;
    s_axis_tuser = w.user; s_axis_tlast = w.last; m_axis_tready = 1'b1;
    @(negedge clk);
    chk("rstmid_load", 64'(s_axis_tready), 64'd1);
    model_push(w);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    bud = 0;
    while (obs_q.size() < base + 2 && bud < 50) begin
      @(posedge clk); #1;
      bud++;
    end
    chk("rstmid_wait", 64'(bud < 50), 64'd1);
    rst = 1'b1;
    m_axis_tready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rstmid_s_tready", 64'(s_axis_tready), 64'd1);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_frames", 64'(stat_frames), 64'd0);
    chk("rstmid_null", 64'(stat_null_beats), 64'd0);
    while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
    exp_frames = 0;
    exp_null   = 0;
    in_q.push_back(mk_beat(32'hFFFF_FFFF, 1'b0));
    in_q.push_back(mk_beat(32'h0000_FFFF, 1'b1));
    run(80, gap);
    compare_all();

    chk("stall_viol", 64'(stall_viol), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
